// File: rtl/frequency_meter_pkg.sv
// freq_meter_pkg: shared state type and default sizing for the frequency meter
package freq_meter_pkg;
  typedef enum logic {IDLE, GATE} state_t;
  localparam int CLK_HZ = 100_000_000;
  localparam int GATE_CYCLES_DEF = CLK_HZ;
  localparam int GLITCH_CYCLES_DEF = 4;
  localparam int COUNT_W_DEF = 24;
endpackage

// File: rtl/frequency_meter_sig_deglitch.sv
// sig_deglitch: synchronizes a sensor pulse, rejects short glitches and flags filtered rising edges
module sig_deglitch
  import freq_meter_pkg::*;
#(
  parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
  input  logic clk_100m,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);
  logic s1, sync, filt, filt_q;
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      s1 <= 1'b0;
      sync <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s1 <= sig_in;
      sync <= s1;
      filt_q <= filt;
    end
  end
  generate
    if (GLITCH_CYCLES == 0) begin : g_bypass
      assign filt = sync;
    end else begin : g_filter
      localparam int RW = $clog2(GLITCH_CYCLES + 1);
      logic [RW-1:0] run;
      logic filt_r;
      // run counts consecutive cycles where sync disagrees with the filtered level
      always_ff @(posedge clk_100m) begin
        if (rst) begin
          run <= '0;
          filt_r <= 1'b0;
        end else if (sync == filt_r) begin
          run <= '0;
        end else if (run == RW'(GLITCH_CYCLES - 1)) begin
          run <= '0;
          filt_r <= sync;
        end else begin
          run <= run + 1'b1;
        end
      end
      assign filt = filt_r;
    end
  endgenerate
  assign rise = filt & ~filt_q;
endmodule

// File: rtl/frequency_meter.sv
// frequency_meter: counts filtered rising edges over back-to-back gate windows and publishes each count
module frequency_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
  input  logic               clk_100m,
  input  logic               rst,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               overflow,
  output logic               no_signal
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [COUNT_W-1:0] CMAX = '1;
  state_t state, state_nxt;
  logic [GW-1:0] gate_cnt;
  logic [COUNT_W-1:0] edge_cnt, edge_sum;
  logic rise, counting, publish;
  sig_deglitch #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_deglitch (
    .clk_100m(clk_100m),
    .rst(rst),
    .sig_in(sig_in),
    .rise(rise)
  );
  assign edge_sum = (rise && edge_cnt != CMAX) ? edge_cnt + 1'b1 : edge_cnt;
  always_comb begin
    state_nxt = en ? GATE : IDLE;
    counting = state == GATE && en;
    publish = counting && gate_cnt == GW'(GATE_CYCLES - 1);
  end
  // dropping en mid-window clears the counters without touching the published outputs
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      overflow <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      state <= state_nxt;
      freq_valid <= publish;
      gate_cnt <= (counting && !publish) ? gate_cnt + 1'b1 : '0;
      edge_cnt <= (counting && !publish) ? edge_sum : '0;
      if (publish) begin
        freq_count <= edge_sum;
        overflow <= edge_sum == CMAX;
        no_signal <= edge_sum == '0;
      end
    end
  end
endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: random and directed stimulus checked against a window-level model of the meter
module tb_frequency_meter;
  localparam int GC = 1000;
  localparam int GL = 4;
  localparam longint MAX24 = (64'd1 << 24) - 1;
  localparam longint MAX4 = 15;
  logic clk_100m = 1'b0, rst, en, sig_in;
  logic [23:0] fc;
  logic [3:0] fc4;
  logic fv, ov, ns, fv4, ov4, ns4;
  int n_cmp = 0, n_fail = 0;
  frequency_meter #(.GATE_CYCLES(GC), .COUNT_W(24), .GLITCH_CYCLES(GL)) dut (
    .clk_100m(clk_100m), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_count(fc), .freq_valid(fv), .overflow(ov), .no_signal(ns)
  );
  frequency_meter #(.GATE_CYCLES(GC), .COUNT_W(4), .GLITCH_CYCLES(GL)) dut4 (
    .clk_100m(clk_100m), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_count(fc4), .freq_valid(fv4), .overflow(ov4), .no_signal(ns4)
  );
  always #5 clk_100m = ~clk_100m;
  function automatic void chk(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction
  // model: sig samples since reset, filtered level, and window bookkeeping in plain arithmetic
  bit sh[$];
  bit fa, fvp, fvn, r, flip, in_gate, live = 0;
  int t, ws;
  longint ecount, e_fc, e_fc4;
  bit e_v, e_ov, e_ov4, e_ns;
  function automatic bit sync_seen(int j);
    int k = sh.size() - 3 - j;
    return k >= 0 ? sh[k] : 1'b0;
  endfunction
  initial forever begin
    @(posedge clk_100m);
    if (rst) begin
      sh.delete();
      fa = 0; fvp = 0; in_gate = 0; t = 0; ecount = 0;
      e_fc = 0; e_fc4 = 0; e_v = 0; e_ov = 0; e_ov4 = 0; e_ns = 0;
      live = 1;
    end else begin
      sh.push_back(sig_in);
      if (sh.size() > GL + 3) void'(sh.pop_front());
      fvn = (GL == 0) ? sync_seen(0) : fa;
      r = fvn & ~fvp;
      flip = GL > 0;
      for (int j = 0; j < GL; j++) if (sync_seen(j) == fa) flip = 0;
      if (flip) fa = ~fa;
      fvp = fvn;
      e_v = 0;
      if (!in_gate) begin
        if (en) begin in_gate = 1; ws = t + 1; ecount = 0; end
      end else if (!en) begin
        in_gate = 0;
      end else begin
        ecount += r;
        if (t == ws + GC - 1) begin
          e_fc = ecount > MAX24 ? MAX24 : ecount;
          e_fc4 = ecount > MAX4 ? MAX4 : ecount;
          e_ov = e_fc == MAX24;
          e_ov4 = e_fc4 == MAX4;
          e_ns = ecount == 0;
          e_v = 1;
          ws = t + 1;
          ecount = 0;
        end
      end
      t++;
    end
  end
  initial forever begin
    @(negedge clk_100m);
    if (live) begin
      chk("freq_count", fc, e_fc);
      chk("freq_valid", fv, e_v);
      chk("overflow", ov, e_ov);
      chk("no_signal", ns, e_ns);
      chk("freq_count_w4", fc4, e_fc4);
      chk("freq_valid_w4", fv4, e_v);
      chk("overflow_w4", ov4, e_ov4);
      chk("no_signal_w4", ns4, e_ns);
    end
  end
  // stimulus: mode 0 constant level, 1 periodic pulse, 2 random run lengths
  int mode = 0, per = 100, hi = 50, ph = 0, rlen = 0, edge_no = 0;
  int vcount = 0, vedge = 0, cap_fc = 0, cap_fc4 = 0, cap_ov = 0, cap_ov4 = 0, cap_ns = 0;
  bit lvl = 0;
  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk_100m);
      edge_no++;
      #1;
      if (mode == 1) begin
        sig_in = (ph % per) < hi;
        ph++;
      end else if (mode == 2) begin
        if (rlen == 0) begin
          lvl = 1'($urandom_range(0, 1));
          rlen = $urandom_range(1, 10);
        end
        rlen--;
        sig_in = lvl;
      end else begin
        sig_in = lvl;
      end
      @(negedge clk_100m);
      if (fv) begin
        vcount++; vedge = edge_no;
        cap_fc = fc; cap_fc4 = fc4; cap_ov = ov; cap_ov4 = ov4; cap_ns = ns;
      end
    end
  endtask
  task automatic wait_valid();
    int v0 = vcount;
    for (int i = 0; i < 1500 && vcount == v0; i++) cycles(1);
    chk("valid_within_window", vcount - v0, 1);
  endtask
  task automatic restart(int m, int p, int h, bit l);
    en = 0; mode = m; per = p; hi = h; lvl = l;
    cycles(20);
    en = 1;
  endtask
  int a, e_set;
  initial begin
    rst = 1; en = 0; lvl = 1; mode = 0; sig_in = 1;
    cycles(3);
    chk("reset_freq_count", fc, 0);
    chk("reset_freq_valid", fv, 0);
    chk("reset_overflow", ov, 0);
    chk("reset_no_signal", ns, 0);
    rst = 0;
    cycles(20);
    en = 1;
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      chk("static_count", cap_fc, 0);
      chk("static_no_signal", cap_ns, 1);
    end
    restart(1, 100, 50, 0);
    wait_valid();
    chk("nominal_count", cap_fc, 10);
    chk("nominal_overflow", cap_ov, 0);
    chk("nominal_no_signal", cap_ns, 0);
    a = vedge;
    wait_valid();
    chk("nominal_period", vedge - a, GC);
    restart(1, 50, 2, 0);
    wait_valid();
    chk("glitch_2cyc_count", cap_fc, 0);
    restart(1, 50, 6, 0);
    wait_valid();
    chk("glitch_6cyc_count", cap_fc, 20);
    restart(1, 20, 10, 0);
    wait_valid();
    chk("sat_count_w4", cap_fc4, 15);
    chk("sat_overflow_w4", cap_ov4, 1);
    chk("sat_count_w24", cap_fc, 50);
    mode = 0; lvl = 0;
    wait_valid();
    chk("sat_next_overflow_w4", cap_ov4, 0);
    wait_valid();
    chk("stopped_count_w4", cap_fc4, 0);
    chk("stopped_overflow_w4", cap_ov4, 0);
    restart(0, 100, 50, 0);
    vcount = 0;
    cycles(993); lvl = 1; cycles(10); lvl = 0; cycles(10);
    chk("term_edge_pulses", vcount, 1);
    chk("term_edge_closing", cap_fc, 1);
    wait_valid();
    chk("term_edge_next", cap_fc, 0);
    restart(0, 100, 50, 0);
    vcount = 0;
    cycles(994); lvl = 1; cycles(10); lvl = 0; cycles(10);
    chk("first_edge_pulses", vcount, 1);
    chk("first_edge_closing", cap_fc, 0);
    wait_valid();
    chk("first_edge_next", cap_fc, 1);
    restart(1, 100, 50, 0);
    wait_valid();
    cycles(500);
    en = 0;
    vcount = 0;
    cycles(1500);
    chk("abort_no_valid", vcount, 0);
    chk("abort_hold_count", fc, 10);
    en = 1;
    e_set = edge_no;
    wait_valid();
    chk("reenable_latency", vedge - e_set, GC + 1);
    cycles(300);
    rst = 1;
    cycles(1);
    chk("midrst_freq_count", fc, 0);
    chk("midrst_freq_valid", fv, 0);
    chk("midrst_overflow", ov, 0);
    chk("midrst_no_signal", ns, 0);
    rst = 0;
    mode = 2;
    for (int i = 0; i < 14; i++) begin
      en = $urandom_range(0, 3) != 0;
      cycles($urandom_range(200, 1500));
      if (i == 7) begin rst = 1; cycles(2); rst = 0; end
    end
    en = 1;
    cycles(2100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
